rx_descrambler_ctrl: RTL and testbench

Sequences the per-lane descramblers of the RX path. It decides, per lane and per cycle, whether each descrambler passes data through or descrambles it, and when each lane reloads its LFSR seed. It sits between the LTSSM substate / PIPE front-end and the 16 descrambler instances, and replaces the ad-hoc enable counter and bypass terms with one registered FSM.

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_lane_mask_dec.sv | 20 ++
 rtl/rx_descrambler_ctrl.sv | 118 +++++++++++
 tb/tb_rx_descrambler_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared RX-path definitions: descrambler control FSM states, LTSSM substate codes
// and the 128b/130b ordered-set sync header value.
package rx_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_ON  = 2'd2
    } descr_state_t;

    localparam logic [4:0] SUBSTATE_CFG_IDLE_CODE = 5'd9;
    localparam logic [4:0] SUBSTATE_DETECT_CODE   = 5'd1;

    localparam logic [1:0] SYNC_HDR_OS = 2'b01;

endpackage

// File: rtl/rx_lane_mask_dec.sv
// Converts a configured lane count into a per-lane enable mask.
// Counts above LANES are clamped, so every lane is then enabled.
module rx_lane_mask_dec #(
    parameter int LANES = 16
) (
    input  logic [4:0]       i_num_lanes,
    output logic [LANES-1:0] o_mask
);

    logic [4:0] w_count;

    always_comb begin
        w_count = (i_num_lanes > 5'(LANES)) ? 5'(LANES) : i_num_lanes;
        o_mask  = '0;
        for (int i = 0; i < LANES; i++) begin
            o_mask[i] = (5'(i) < w_count);
        end
    end

endmodule

// File: rtl/rx_descrambler_ctrl.sv
// RX descrambler sequencer: OFF/ARM/ON FSM driving per-lane bypass and seed reload.
// Optional macro RX_DESCR_ZERO_BYPASS_EN bypasses all lanes on all-zero logical idle data.
module rx_descrambler_ctrl #(
    parameter int         LANES             = 16,
    parameter int         ENABLE_DELAY      = 2,
    parameter logic [4:0] SUBSTATE_CFG_IDLE = rx_pkg::SUBSTATE_CFG_IDLE_CODE,
    parameter logic [4:0] SUBSTATE_DETECT   = rx_pkg::SUBSTATE_DETECT_CODE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           i_gen,
    input  logic [4:0]           i_substate,
    input  logic                 i_disable_scrambler,
    input  logic [LANES-1:0]     i_os_detect,
    input  logic [2*LANES-1:0]   i_sync_header,
    input  logic [LANES-1:0]     i_data_valid,
    input  logic                 i_lane_data_zero,
    input  logic [4:0]           i_num_lanes,
    output logic [LANES-1:0]     o_descr_off,
    output logic [LANES-1:0]     o_seed_load,
    output logic [1:0]           o_ctrl_state,
    output logic                 o_descr_active
);

    import rx_pkg::*;

    localparam logic [2:0] CNT_LAST = 3'(ENABLE_DELAY - 1);

    descr_state_t     r_state;
    descr_state_t     w_next;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_next;
    logic [LANES-1:0] r_descr_off;
    logic [LANES-1:0] r_seed_load;
    logic [LANES-1:0] w_descr_off;
    logic [LANES-1:0] w_seed_load;
    logic [LANES-1:0] w_mask;
    logic             w_zero_bypass;
    logic             w_in_idle;

    rx_lane_mask_dec #(
        .LANES (LANES)
    ) u_mask_dec (
        .i_num_lanes (i_num_lanes),
        .o_mask      (w_mask)
    );

    assign w_in_idle = (i_substate == SUBSTATE_CFG_IDLE);

    always_comb begin
`ifdef RX_DESCR_ZERO_BYPASS_EN
        w_zero_bypass = i_lane_data_zero & w_in_idle;
`else
        w_zero_bypass = i_lane_data_zero & 1'b0;
`endif
    end

    always_comb begin
        w_next = r_state;
        if (i_substate == SUBSTATE_DETECT) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: if (w_in_idle && !i_disable_scrambler) w_next = ST_ARM;
                ST_ARM: begin
                    if (i_disable_scrambler || !w_in_idle) w_next = ST_OFF;
                    else if (r_cnt == CNT_LAST)            w_next = ST_ON;
                end
                ST_ON:  if (i_disable_scrambler) w_next = ST_OFF;
                default: w_next = ST_OFF;
            endcase
        end
    end

    // Outputs are computed for the upcoming state so they register alongside it.
    always_comb begin
        w_cnt_next  = '0;
        w_descr_off = '1;
        w_seed_load = '0;
        if (r_state == ST_ARM && w_next == ST_ARM) begin
            w_cnt_next = r_cnt + 3'd1;
        end
        if (w_next == ST_ON) begin
            for (int i = 0; i < LANES; i++) begin
                w_descr_off[i] = i_os_detect[i]
                               | ((i_gen >= 3'd3) && (i_sync_header[2*i +: 2] == SYNC_HDR_OS))
                               | !w_mask[i]
                               | !i_data_valid[i]
                               | w_zero_bypass;
            end
            if (r_state == ST_ARM) begin
                w_seed_load = w_mask;
            end else if (i_gen <= 3'd2) begin
                w_seed_load = i_os_detect & i_data_valid & w_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_descr_off <= '1;
            r_seed_load <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_descr_off <= w_descr_off;
            r_seed_load <= w_seed_load;
        end
    end

    assign o_descr_off    = r_descr_off;
    assign o_seed_load    = r_seed_load;
    assign o_ctrl_state   = r_state;
    assign o_descr_active = (r_state == ST_ON);

endmodule

// File: tb/tb_rx_descrambler_ctrl.sv
// Directed bench for rx_descrambler_ctrl (LANES=16, ENABLE_DELAY=2).
// Zero-bypass expectations follow RX_DESCR_ZERO_BYPASS_EN.
module tb_rx_descrambler_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  gen;
    logic [4:0]  substate;
    logic        dis;
    logic [15:0] os_detect;
    logic [31:0] sync_header;
    logic [15:0] data_valid;
    logic        lane_data_zero;
    logic [4:0]  num_lanes;
    logic [15:0] descr_off;
    logic [15:0] seed_load;
    logic [1:0]  ctrl_state;
    logic        descr_active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_descrambler_ctrl #(
        .LANES        (16),
        .ENABLE_DELAY (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_gen               (gen),
        .i_substate          (substate),
        .i_disable_scrambler (dis),
        .i_os_detect         (os_detect),
        .i_sync_header       (sync_header),
        .i_data_valid        (data_valid),
        .i_lane_data_zero    (lane_data_zero),
        .i_num_lanes         (num_lanes),
        .o_descr_off         (descr_off),
        .o_seed_load         (seed_load),
        .o_ctrl_state        (ctrl_state),
        .o_descr_active      (descr_active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; gen = 3'd1; substate = 5'd0; dis = 1'b0;
        os_detect = '0; sync_header = '0; data_valid = 16'hFFFF;
        lane_data_zero = 1'b0; num_lanes = 5'd16;
        step(); step();
        checks++; if (descr_off !== 16'hFFFF) begin failures++; $display("FAIL reset_off got=%h exp=ffff", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL reset_seed got=%h exp=0000", seed_load); end
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ctrl_state); end
        checks++; if (descr_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", descr_active); end
    endtask

    task automatic test_enable();
        reset = 1'b1; substate = 5'd9; num_lanes = 5'd8;
        step();
        checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL en_arm1 got=%0d exp=1", ctrl_state); end
        checks++; if (descr_off !== 16'hFFFF) begin failures++; $display("FAIL en_arm_off got=%h exp=ffff", descr_off); end
        step();
        checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL en_arm2 got=%0d exp=1", ctrl_state); end
        step();
        checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL en_on got=%0d exp=2", ctrl_state); end
        checks++; if (descr_off !== 16'hFF00) begin failures++; $display("FAIL en_off got=%h exp=ff00", descr_off); end
        checks++; if (seed_load !== 16'h00FF) begin failures++; $display("FAIL en_seed got=%h exp=00ff", seed_load); end
        checks++; if (descr_active !== 1'b1) begin failures++; $display("FAIL en_active got=%b exp=1", descr_active); end
        step();
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL en_seed_once got=%h exp=0000", seed_load); end
        checks++; if (descr_off !== 16'hFF00) begin failures++; $display("FAIL en_off_hold got=%h exp=ff00", descr_off); end
    endtask

    task automatic test_lane_mask();
        num_lanes = 5'd4; data_valid = 16'h000A;
        step();
        checks++; if (descr_off !== 16'hFFF5) begin failures++; $display("FAIL mask_dv got=%h exp=fff5", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL mask_seed got=%h exp=0000", seed_load); end
        data_valid = 16'hFFFF;
        step();
        checks++; if (descr_off !== 16'hFFF0) begin failures++; $display("FAIL mask_all got=%h exp=fff0", descr_off); end
    endtask

    task automatic test_os_block();
        num_lanes = 5'd16; gen = 3'd3; sync_header = 32'h0000_0010;
        step();
        checks++; if (descr_off !== 16'h0004) begin failures++; $display("FAIL osblk_off got=%h exp=0004", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL osblk_seed got=%h exp=0000", seed_load); end
        sync_header = '0; os_detect = 16'h0002;
        step();
        checks++; if (descr_off !== 16'h0002) begin failures++; $display("FAIL g3os_off got=%h exp=0002", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL g3os_seed got=%h exp=0000", seed_load); end
        os_detect = '0;
        step();
        checks++; if (descr_off !== 16'h0000) begin failures++; $display("FAIL osblk_clear got=%h exp=0000", descr_off); end
    endtask

    task automatic test_gen1_com();
        gen = 3'd1; os_detect = 16'h0001;
        step();
        checks++; if (seed_load !== 16'h0001) begin failures++; $display("FAIL com_seed got=%h exp=0001", seed_load); end
        checks++; if (descr_off !== 16'h0001) begin failures++; $display("FAIL com_off got=%h exp=0001", descr_off); end
        os_detect = 16'h0003; data_valid = 16'hFFFE;
        step();
        checks++; if (seed_load !== 16'h0002) begin failures++; $display("FAIL com_dv_seed got=%h exp=0002", seed_load); end
        checks++; if (descr_off !== 16'h0003) begin failures++; $display("FAIL com_dv_off got=%h exp=0003", descr_off); end
        os_detect = '0; data_valid = 16'hFFFF;
        step();
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL com_clear got=%h exp=0000", seed_load); end
    endtask

    task automatic test_zero_bypass();
        logic [15:0] expOff;
`ifdef RX_DESCR_ZERO_BYPASS_EN
        expOff = 16'hFFFF;
`else
        expOff = 16'h0000;
`endif
        lane_data_zero = 1'b1;
        step();
        checks++; if (descr_off !== expOff) begin failures++; $display("FAIL zero_off got=%h exp=%h", descr_off, expOff); end
        checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL zero_state got=%0d exp=2", ctrl_state); end
        lane_data_zero = 1'b0;
        step();
        checks++; if (descr_off !== 16'h0000) begin failures++; $display("FAIL zero_clear got=%h exp=0000", descr_off); end
    endtask

    task automatic test_detect_shutdown();
        substate = 5'd5;
        step();
        checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL on_hold got=%0d exp=2", ctrl_state); end
        substate = 5'd1; dis = 1'b1; os_detect = 16'h0001;
        step();
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL det_state got=%0d exp=0", ctrl_state); end
        checks++; if (descr_off !== 16'hFFFF) begin failures++; $display("FAIL det_off got=%h exp=ffff", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL det_seed got=%h exp=0000", seed_load); end
        checks++; if (descr_active !== 1'b0) begin failures++; $display("FAIL det_active got=%b exp=0", descr_active); end
        dis = 1'b0; os_detect = '0; substate = 5'd0;
        step();
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL off_idle got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_disable_race();
        substate = 5'd9;
        step(); step();
        checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL race_arm got=%0d exp=1", ctrl_state); end
        dis = 1'b1;
        step();
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL race_state got=%0d exp=0", ctrl_state); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL race_seed got=%h exp=0000", seed_load); end
        dis = 1'b0;
        step();
        checks++; if (ctrl_state !== 2'd1) begin failures++; $display("FAIL rearm got=%0d exp=1", ctrl_state); end
        substate = 5'd5;
        step();
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL arm_abort got=%0d exp=0", ctrl_state); end
    endtask

    task automatic test_num_lanes_bounds();
        substate = 5'd9; num_lanes = 5'd0;
        step(); step(); step();
        checks++; if (ctrl_state !== 2'd2) begin failures++; $display("FAIL nl0_state got=%0d exp=2", ctrl_state); end
        checks++; if (descr_off !== 16'hFFFF) begin failures++; $display("FAIL nl0_off got=%h exp=ffff", descr_off); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL nl0_seed got=%h exp=0000", seed_load); end
        num_lanes = 5'd20;
        step();
        checks++; if (descr_off !== 16'h0000) begin failures++; $display("FAIL nl20_off got=%h exp=0000", descr_off); end
    endtask

    task automatic test_reset_mid();
        gen = 3'd1; os_detect = 16'hFFFF; reset = 1'b0;
        step();
        checks++; if (ctrl_state !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", ctrl_state); end
        checks++; if (seed_load !== 16'h0000) begin failures++; $display("FAIL rmid_seed got=%h exp=0000", seed_load); end
        checks++; if (descr_off !== 16'hFFFF) begin failures++; $display("FAIL rmid_off got=%h exp=ffff", descr_off); end
        reset = 1'b1; os_detect = '0; substate = 5'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_enable();
        test_lane_mask();
        test_os_block();
        test_gen1_com();
        test_zero_bypass();
        test_detect_shutdown();
        test_disable_race();
        test_num_lanes_bounds();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
